// File: rtl/fetch_decode_queue_if.sv
// Handshake bundle between instr_fetch, the fetch/decode queue and decode.
// The slave modport is the queue's view; the master modport is the
// surrounding pipeline (fetch + decode) view.
interface fetch_decode_queue_if #(
  parameter int ADDR_SIZE = 32,
  parameter int INST_SIZE = 32,
  parameter int DEPTH     = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  // fetch -> queue
  logic [INST_SIZE-1:0] i_instruction;
  logic [ADDR_SIZE-1:0] i_pc;
  logic [ADDR_SIZE-1:0] i_pcplus4;
  logic                 i_instr_valid;
  logic                 i_flush;
  logic                 o_fetch_en;

  // queue -> decode
  logic [INST_SIZE-1:0] o_instruction;
  logic [ADDR_SIZE-1:0] o_pc;
  logic [ADDR_SIZE-1:0] o_pcplus4;
  logic                 o_valid;
  logic                 i_dec_ready;

  // status
  logic [CW-1:0]        o_count;
  logic                 o_overflow;

  modport master (
    output i_instruction, i_pc, i_pcplus4, i_instr_valid, i_flush, i_dec_ready,
    input  o_fetch_en, o_instruction, o_pc, o_pcplus4, o_valid, o_count, o_overflow
  );

  modport slave (
    input  i_instruction, i_pc, i_pcplus4, i_instr_valid, i_flush, i_dec_ready,
    output o_fetch_en, o_instruction, o_pc, o_pcplus4, o_valid, o_count, o_overflow
  );
endinterface

// File: rtl/fetch_decode_queue.sv
// First-word-fall-through instruction queue between instr_fetch and decode.
// Buffers {instruction, pc, pcplus4}, throttles fetch so one in-flight cache
// response always has a slot, and drops everything on a branch redirect.
module fetch_decode_queue #(
  parameter int ADDR_SIZE = 32,
  parameter int INST_SIZE = 32,
  parameter int DEPTH     = 4,
  parameter int SLACK     = 1
) (
  input  logic                 i_aclk,
  input  logic                 i_reset,
  fetch_decode_queue_if.slave  bus
);

  localparam int PW     = $clog2(DEPTH);
  localparam int CW     = PW + 1;
  localparam int THRESH = DEPTH - 1 - SLACK;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH_C = CW'(THRESH);

  typedef struct packed {
    logic [INST_SIZE-1:0] instr;
    logic [ADDR_SIZE-1:0] pc;
    logic [ADDR_SIZE-1:0] pcplus4;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          overflow_q;
  logic          fetch_en_q;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  // Handshake decode and next occupancy; a flush wins over push and pop.
  // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
  always_comb begin
    full    = (cnt == DEPTH_C);
    pop     = (cnt != '0) & bus.i_dec_ready;
    push    = bus.i_instr_valid & ~bus.i_flush & (~full | pop);
    drop    = bus.i_instr_valid & ~bus.i_flush & full & ~pop;
    cnt_nxt = cnt;
    if (bus.i_flush) begin
      cnt_nxt = '0;
    end else if (push && !pop) begin
      cnt_nxt = cnt + CW'(1);
    end else if (pop && !push) begin
      cnt_nxt = cnt - CW'(1);
    end
  end

  // Control state: pointers, occupancy, sticky overflow and registered fetch enable.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_aclk) begin
    if (i_reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      cnt        <= '0;
      overflow_q <= 1'b0;
      fetch_en_q <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      fetch_en_q <= (cnt_nxt <= THRESH_C);
      if (bus.i_flush) begin
        rd_ptr <= wr_ptr;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
      if (drop) overflow_q <= 1'b1;
    end
  end

  // Entry storage write port.
  // NOTE: the entry array is deliberately not reset; o_valid masks stale contents and it maps to plain RAM.
  always_ff @(posedge i_aclk) begin
    if (push && !i_reset) begin
      mem[wr_ptr] <= '{instr: bus.i_instruction, pc: bus.i_pc, pcplus4: bus.i_pcplus4};
    end
  end

  assign bus.o_instruction = mem[rd_ptr].instr;
  assign bus.o_pc          = mem[rd_ptr].pc;
  assign bus.o_pcplus4     = mem[rd_ptr].pcplus4;
  assign bus.o_valid       = (cnt != '0);
  assign bus.o_count       = cnt;
  assign bus.o_overflow    = overflow_q;
  assign bus.o_fetch_en    = fetch_en_q;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed bench for fetch_decode_queue: a stimulus process pushes expected
// entries into a scoreboard queue, and a monitor pops and compares them
// whenever decode actually takes the head.
module tb_fetch_decode_queue;

  localparam int ADDR_SIZE = 32;
  localparam int INST_SIZE = 32;
  localparam int DEPTH     = 4;
  localparam int SLACK     = 1;

  logic i_aclk = 1'b0;
  logic i_reset;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];

  fetch_decode_queue_if #(.ADDR_SIZE(ADDR_SIZE), .INST_SIZE(INST_SIZE), .DEPTH(DEPTH)) bus ();

  fetch_decode_queue #(
    .ADDR_SIZE(ADDR_SIZE),
    .INST_SIZE(INST_SIZE),
    .DEPTH    (DEPTH),
    .SLACK    (SLACK)
  ) dut (
    .i_aclk  (i_aclk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  always #5 i_aclk = ~i_aclk;

  // Instruction word tied to its pc so the monitor can check all head fields.
  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {pc[15:0], 16'hC0DE};
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge i_aclk);
    #1;
  endtask

  task automatic drive(input logic valid, input logic [31:0] pc, input logic ready, input logic flush);
    bus.i_instr_valid = valid;
    bus.i_pc          = pc;
    bus.i_pcplus4     = pc + 32'd4;
    bus.i_instruction = instr_of(pc);
    bus.i_dec_ready   = ready;
    bus.i_flush       = flush;
  endtask

  // Push that the queue must accept; its pc joins the expected output order.
  task automatic push_exp(input logic [31:0] pc, input logic ready);
    drive(1'b1, pc, ready, 1'b0);
    exp_q.push_back(pc);
  endtask

  // Monitor: compare the head whenever decode really pops it.
  always @(negedge i_aclk) begin
    if (i_reset === 1'b0 && bus.o_valid === 1'b1 && bus.i_dec_ready === 1'b1 && bus.i_flush === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pop: got pc 0x%0h expected nothing", bus.o_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("pop_pc", bus.o_pc, e);
        check("pop_pcplus4", bus.o_pcplus4, e + 32'd4);
        check("pop_instr", bus.o_instruction, instr_of(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    check("rst_count", 32'(bus.o_count), 32'd0);
    check("rst_valid", 32'(bus.o_valid), 32'd0);
    check("rst_overflow", 32'(bus.o_overflow), 32'd0);
    check("rst_fetch_en", 32'(bus.o_fetch_en), 32'd0);

    // Reset then fill three entries with decode stalled.
    i_reset = 1'b0;
    push_exp(32'h1000, 1'b0);
    tick();
    check("fill1_valid", 32'(bus.o_valid), 32'd1);
    check("fill1_pc", bus.o_pc, 32'h1000);
    check("fill1_count", 32'(bus.o_count), 32'd1);
    check("fill1_fetch_en", 32'(bus.o_fetch_en), 32'd1);
    push_exp(32'h1004, 1'b0);
    tick();
    check("fill2_count", 32'(bus.o_count), 32'd2);
    check("fill2_fetch_en", 32'(bus.o_fetch_en), 32'd1);
    push_exp(32'h1008, 1'b0);
    tick();
    check("fill3_count", 32'(bus.o_count), 32'd3);
    check("fill3_fetch_en", 32'(bus.o_fetch_en), 32'd0);
    check("fill3_head", bus.o_pc, 32'h1000);

    // Drain in order.
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    check("drain_valid", 32'(bus.o_valid), 32'd0);
    check("drain_count", 32'(bus.o_count), 32'd0);
    check("drain_fetch_en", 32'(bus.o_fetch_en), 32'd1);

    // Fill to DEPTH, then push and pop together while full.
    for (int i = 0; i < 4; i++) begin
      push_exp(32'h2000 + 32'(4 * i), 1'b0);
      tick();
    end
    check("full_count", 32'(bus.o_count), 32'd4);
    check("full_fetch_en", 32'(bus.o_fetch_en), 32'd0);
    push_exp(32'h2010, 1'b1);
    tick();
    check("full_pp_count", 32'(bus.o_count), 32'd4);
    check("full_pp_overflow", 32'(bus.o_overflow), 32'd0);
    check("full_pp_head", bus.o_pc, 32'h2004);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    check("full_drain_count", 32'(bus.o_count), 32'd0);

    // Overflow: push into a full queue with decode stalled.
    for (int i = 0; i < 4; i++) begin
      push_exp(32'h2100 + 32'(4 * i), 1'b0);
      tick();
    end
    drive(1'b1, 32'h3000, 1'b0, 1'b0);
    tick();
    check("ovf_count", 32'(bus.o_count), 32'd4);
    check("ovf_flag", 32'(bus.o_overflow), 32'd1);
    check("ovf_head", bus.o_pc, 32'h2100);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    exp_q.delete();
    check("ovf_flush_valid", 32'(bus.o_valid), 32'd0);
    check("ovf_flush_count", 32'(bus.o_count), 32'd0);
    check("ovf_sticky", 32'(bus.o_overflow), 32'd1);
    check("ovf_flush_fetch_en", 32'(bus.o_fetch_en), 32'd1);

    // Flush with a concurrent push and pop.
    for (int i = 0; i < 3; i++) begin
      push_exp(32'h5000 + 32'(4 * i), 1'b0);
      tick();
    end
    check("fl_pre_count", 32'(bus.o_count), 32'd3);
    drive(1'b1, 32'h500C, 1'b1, 1'b1);
    tick();
    exp_q.delete();
    check("fl_valid", 32'(bus.o_valid), 32'd0);
    check("fl_count", 32'(bus.o_count), 32'd0);
    push_exp(32'h4000, 1'b0);
    tick();
    check("fl_push_valid", 32'(bus.o_valid), 32'd1);
    check("fl_push_pc", bus.o_pc, 32'h4000);
    check("fl_push_count", 32'(bus.o_count), 32'd1);
    push_exp(32'h4004, 1'b0);
    tick();
    check("mid_pre_count", 32'(bus.o_count), 32'd2);

    // Reset mid-operation while a push is offered.
    i_reset = 1'b1;
    drive(1'b1, 32'h4008, 1'b0, 1'b0);
    tick();
    exp_q.delete();
    check("mid_rst_count", 32'(bus.o_count), 32'd0);
    check("mid_rst_valid", 32'(bus.o_valid), 32'd0);
    check("mid_rst_overflow", 32'(bus.o_overflow), 32'd0);
    check("mid_rst_fetch_en", 32'(bus.o_fetch_en), 32'd0);
    i_reset = 1'b0;
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    check("post_rst_fetch_en", 32'(bus.o_fetch_en), 32'd1);
    check("post_rst_count", 32'(bus.o_count), 32'd0);

    tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
